// File: rtl/pong_engine.sv
// Pong game core: frame-tick physics, serve/play/pause/over FSM, scoring,
// and a registered pixel renderer driven by external VGA counters.
module pong_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PAD_MARGIN   = 16,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_STEP    = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 8,
  parameter int COLOR_W      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            hcount,
  input  logic [10:0]            vcount,
  input  logic                   blank,
  input  logic [31:0]            y_pos_1,
  input  logic [31:0]            y_pos_2,
  input  logic [31:0]            ctrl,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B,
  output logic [2*SCORE_W-1:0]   score,
  output logic                   game_over,
  output logic [2:0]             state
);
  localparam int CX   = (H_RES - BALL_SIZE) / 2;
  localparam int CY   = (V_RES - BALL_SIZE) / 2;
  localparam int LF   = PAD_MARGIN + PADDLE_W;
  localparam int RF   = H_RES - PAD_MARGIN - PADDLE_W - BALL_SIZE;
  localparam int XMAX = H_RES - BALL_SIZE;
  localparam int YMAX = V_RES - BALL_SIZE;
  localparam int PMAX = V_RES - PADDLE_H;

  localparam logic signed [12:0] STEP_S = 13'(BALL_STEP);
  localparam logic signed [12:0] ZERO_S = 13'sd0;
  localparam logic signed [12:0] LF_S   = 13'(LF);
  localparam logic signed [12:0] RF_S   = 13'(RF);
  localparam logic signed [12:0] XMAX_S = 13'(XMAX);
  localparam logic signed [12:0] YMAX_S = 13'(YMAX);

  localparam logic [COLOR_W-1:0] C_MAX  = '1;
  localparam logic [COLOR_W-1:0] C_HALF = COLOR_W'(1) << (COLOR_W - 1);
  localparam logic [COLOR_W-1:0] C_QTR  = COLOR_W'(1) << (COLOR_W - 2);

  typedef enum logic [2:0] {
    IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, PAUSE = 3'd3, OVER = 3'd4
  } state_t;

  state_t             st, st_n;
  logic               eq, eq_d, tick;
  logic [10:0]        bx, by, bx_n, by_n, p1, p2, p1_n, p2_n;
  logic               dx, dy, dx_n, dy_n;   // dx=1 moving right, dy=1 moving down
  logic [SCORE_W-1:0] s1, s2, s1_n, s2_n;
  logic [15:0]        cnt, cnt_n;
  logic signed [12:0] nx, ny;
  logic               ov1, ov2, pt1, pt2;
  logic               run, pause, restart, unused;

  assign run     = ctrl[0];
  assign pause   = ctrl[1];
  assign restart = ctrl[2];
  assign unused  = ^ctrl[31:3];

  assign ov1 = (({1'b0, by} + 12'(BALL_SIZE)) > {1'b0, p1}) && ({1'b0, by} < ({1'b0, p1} + 12'(PADDLE_H)));
  assign ov2 = (({1'b0, by} + 12'(BALL_SIZE)) > {1'b0, p2}) && ({1'b0, by} < ({1'b0, p2} + 12'(PADDLE_H)));

  always_comb begin
    st_n = st; bx_n = bx; by_n = by; dx_n = dx; dy_n = dy;
    p1_n = p1; p2_n = p2; s1_n = s1; s2_n = s2; cnt_n = cnt;
    pt1 = 1'b0; pt2 = 1'b0;
    ny = $signed({2'b00, by}) + (dy ? STEP_S : -STEP_S);
    nx = $signed({2'b00, bx}) + (dx ? STEP_S : -STEP_S);
    if (tick) begin
      p1_n = (y_pos_1 > 32'(PMAX)) ? 11'(PMAX) : y_pos_1[10:0];
      p2_n = (y_pos_2 > 32'(PMAX)) ? 11'(PMAX) : y_pos_2[10:0];
      case (st)
        IDLE:  if (run) st_n = SERVE;
        SERVE: if (cnt == 16'(SERVE_FRAMES - 1)) begin
                 cnt_n = '0;
                 st_n  = PLAY;
               end else cnt_n = cnt + 16'd1;
        PLAY:  if (pause) st_n = PAUSE;
               else begin
                 if (ny <= ZERO_S) begin
                   by_n = '0; dy_n = 1'b1;
                 end else if (ny >= YMAX_S) begin
                   by_n = 11'(YMAX); dy_n = 1'b0;
                 end else by_n = ny[10:0];
                 bx_n = nx[10:0];
                 if (!dx && nx <= LF_S && ov1) begin
                   bx_n = 11'(LF); dx_n = 1'b1;
                 end else if (!dx && nx <= ZERO_S) pt2 = 1'b1;
                 else if (dx && nx >= RF_S && ov2) begin
                   bx_n = 11'(RF); dx_n = 1'b0;
                 end else if (dx && nx >= XMAX_S) pt1 = 1'b1;
               end
        PAUSE: if (!pause) st_n = PLAY;
        default: ;
      endcase
    end
    // A point freezes the ball; the serve re-centres it unless the game is won.
    if (pt1 || pt2) begin
      if (pt1) s1_n = s1 + 1'b1;
      else     s2_n = s2 + 1'b1;
      bx_n = bx; by_n = by; dx_n = dx; dy_n = dy;
      if ((pt1 && s1_n == SCORE_W'(WIN_SCORE)) || (pt2 && s2_n == SCORE_W'(WIN_SCORE)))
        st_n = OVER;
      else begin
        st_n = SERVE; cnt_n = '0;
        bx_n = 11'(CX); by_n = 11'(CY); dx_n = pt1;
      end
    end
    if (restart) begin
      st_n = IDLE; s1_n = '0; s2_n = '0; cnt_n = '0;
      bx_n = 11'(CX); by_n = 11'(CY); dx_n = 1'b1; dy_n = 1'b1;
    end
  end

  // Edge detector resets "high" so a reset while vcount sits at V_RES cannot tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE; bx <= 11'(CX); by <= 11'(CY); dx <= 1'b1; dy <= 1'b1;
      p1 <= 11'(PMAX / 2); p2 <= 11'(PMAX / 2);
      s1 <= '0; s2 <= '0; cnt <= '0;
      eq <= 1'b1; eq_d <= 1'b1; tick <= 1'b0;
    end else begin
      eq   <= (vcount == 11'(V_RES));
      eq_d <= eq;
      tick <= eq & ~eq_d;
      st <= st_n; bx <= bx_n; by <= by_n; dx <= dx_n; dy <= dy_n;
      p1 <= p1_n; p2 <= p2_n; s1 <= s1_n; s2 <= s2_n; cnt <= cnt_n;
    end
  end

  assign score     = {s1, s2};
  assign game_over = (st == OVER);
  assign state     = st;

  logic [11:0] h, v;
  logic        in_ball, in_p1, in_p2, in_net;
  assign h = {1'b0, hcount};
  assign v = {1'b0, vcount};
  assign in_ball = (h >= {1'b0, bx}) && (h < {1'b0, bx} + 12'(BALL_SIZE)) &&
                   (v >= {1'b0, by}) && (v < {1'b0, by} + 12'(BALL_SIZE));
  assign in_p1 = (h >= 12'(PAD_MARGIN)) && (h < 12'(PAD_MARGIN + PADDLE_W)) &&
                 (v >= {1'b0, p1}) && (v < {1'b0, p1} + 12'(PADDLE_H));
  assign in_p2 = (h >= 12'(H_RES - PAD_MARGIN - PADDLE_W)) && (h < 12'(H_RES - PAD_MARGIN)) &&
                 (v >= {1'b0, p2}) && (v < {1'b0, p2} + 12'(PADDLE_H));
  assign in_net = ((hcount == 11'(H_RES / 2 - 1)) || (hcount == 11'(H_RES / 2))) && !vcount[3];

  always_ff @(posedge clk) begin
    if (reset || blank) begin
      VGA_R <= '0; VGA_G <= '0; VGA_B <= '0;
    end else if (in_ball) begin
      VGA_R <= C_MAX; VGA_G <= C_MAX; VGA_B <= C_MAX;
    end else if (in_p1) begin
      VGA_R <= '0; VGA_G <= C_MAX; VGA_B <= '0;
    end else if (in_p2) begin
      VGA_R <= '0; VGA_G <= '0; VGA_B <= C_MAX;
    end else if (in_net) begin
      VGA_R <= C_HALF; VGA_G <= C_HALF; VGA_B <= C_HALF;
    end else begin
      VGA_R <= (st == OVER) ? C_QTR : '0; VGA_G <= '0; VGA_B <= '0;
    end
  end
endmodule

// File: tb/tb_pong_engine.sv
// Scoreboard bench for pong_engine: a game model predicts score/state per
// frame and pixel colour per probe; the DUT is compared as results appear.
module tb_pong_engine;
  logic        clk = 1'b0;
  logic        reset, blank;
  logic [10:0] hcount, vcount;
  logic [31:0] y_pos_1, y_pos_2, ctrl;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic [15:0] score;
  logic        game_over;
  logic [2:0]  state;

  pong_engine dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .blank(blank),
    .y_pos_1(y_pos_1), .y_pos_2(y_pos_2), .ctrl(ctrl),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .score(score), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  int mx, my, mdx, mdy, mp1, mp2, ms1, ms2, mst, mcnt;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(string tag, logic [31:0] val);
    exp_t e;
    e.tag = tag; e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk(e.tag, act, e.val);
  endtask

  task automatic model_restart();
    mx = 316; my = 236; mdx = 1; mdy = 1; ms1 = 0; ms2 = 0; mst = 0; mcnt = 0;
  endtask

  function automatic int clampp(logic [31:0] y);
    return (y > 32'd416) ? 416 : int'(y);
  endfunction

  task automatic model_tick(bit run, bit pause, logic [31:0] y1, logic [31:0] y2);
    int op1 = mp1, op2 = mp2, tx, ty, tdx, tdy, pt;
    mp1 = clampp(y1); mp2 = clampp(y2);
    case (mst)
      0: if (run) mst = 1;
      1: if (mcnt == 59) begin mcnt = 0; mst = 2; end else mcnt++;
      2: if (pause) mst = 3;
         else begin
           ty = my + (mdy ? 2 : -2); tdy = mdy;
           if (ty <= 0) begin ty = 0; tdy = 1; end
           else if (ty >= 472) begin ty = 472; tdy = 0; end
           tx = mx + (mdx ? 2 : -2); tdx = mdx; pt = 0;
           if (mdx == 0 && tx <= 24) begin
             if (my + 8 > op1 && my < op1 + 64) begin tx = 24; tdx = 1; end
             else if (tx <= 0) pt = 2;
           end else if (mdx == 1 && tx >= 608) begin
             if (my + 8 > op2 && my < op2 + 64) begin tx = 608; tdx = 0; end
             else if (tx >= 632) pt = 1;
           end
           if (pt == 0) begin mx = tx; my = ty; mdx = tdx; mdy = tdy; end
           else begin
             if (pt == 1) ms1++; else ms2++;
             if (ms1 == 9 || ms2 == 9) mst = 4;
             else begin mst = 1; mcnt = 0; mx = 316; my = 236; mdx = (pt == 1); end
           end
         end
      3: if (!pause) mst = 2;
      default: ;
    endcase
  endtask

  function automatic logic [11:0] exp_pix(int hh, int vv, bit bl);
    if (bl) return 12'h000;
    if (hh >= mx && hh < mx + 8 && vv >= my && vv < my + 8) return 12'hFFF;
    if (hh >= 16 && hh < 24 && vv >= mp1 && vv < mp1 + 64) return 12'h0F0;
    if (hh >= 616 && hh < 624 && vv >= mp2 && vv < mp2 + 64) return 12'h00F;
    if ((hh == 319 || hh == 320) && (vv % 16) < 8) return 12'h888;
    return (mst == 4) ? 12'h400 : 12'h000;
  endfunction

  task automatic do_frame(string tag);
    logic [31:0] e;
    model_tick(ctrl[0], ctrl[1], y_pos_1, y_pos_2);
    e = {12'd0, 1'(mst == 4), 3'(mst), 8'(ms1), 8'(ms2)};
    sb_push(tag, e);
    @(negedge clk) vcount = 11'd480;
    @(negedge clk) vcount = 11'd0;
    @(negedge clk);
    @(negedge clk);
    sb_pop({12'd0, game_over, state, score});
  endtask

  task automatic probe(string tag, int hh, int vv, bit bl);
    @(negedge clk);
    hcount = 11'(hh); vcount = 11'(vv); blank = bl;
    sb_push(tag, 32'(exp_pix(hh, vv, bl)));
    @(negedge clk) sb_pop(32'({VGA_R, VGA_G, VGA_B}));
    blank = 1'b0; vcount = 11'd0;
  endtask

  // Paddle steering: 1 tracks the ball, 2 keeps clear of it, 0 leaves it.
  task automatic steer(int m1, int m2);
    int t = (my >= 20) ? my - 20 : 0;
    int a = (my < 240) ? 416 : 0;
    if (m1 == 1) y_pos_1 = 32'(t); else if (m1 == 2) y_pos_1 = 32'(a);
    if (m2 == 1) y_pos_2 = 32'(t); else if (m2 == 2) y_pos_2 = 32'(a);
  endtask

  initial begin
    reset = 1'b1; ctrl = '0; hcount = '0; vcount = '0; blank = 1'b0;
    y_pos_1 = 32'd208; y_pos_2 = 32'd208;
    model_restart(); mp1 = 208; mp2 = 208;
    repeat (3) @(negedge clk);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
    reset = 1'b0;

    probe("ball_ctr", 316, 236, 0);
    probe("ball_corner", 323, 243, 0);
    probe("ball_right_out", 324, 236, 0);
    probe("pad1_top", 16, 208, 0);
    probe("pad1_above", 16, 207, 0);
    probe("pad2_bot", 623, 271, 0);
    probe("net", 319, 0, 0);
    probe("net_gap", 320, 8, 0);
    probe("blank", 316, 236, 1);

    ctrl = 32'd1;
    do_frame("run");
    chk("serve_state", 32'(state), 32'd1);
    repeat (59) do_frame("serve");
    chk("still_serve", 32'(state), 32'd1);
    do_frame("serve_end");
    chk("play_state", 32'(state), 32'd2);
    repeat (3) do_frame("play");
    probe("ball_moved", 322, 242, 0);
    probe("ball_old_spot", 316, 236, 0);

    ctrl = 32'd3;
    do_frame("pause");
    chk("pause_state", 32'(state), 32'd3);
    do_frame("paused");
    probe("ball_frozen", mx, my, 0);
    ctrl = 32'd1;
    do_frame("resume");
    chk("resume_state", 32'(state), 32'd2);

    for (int i = 0; i < 400 && mdx == 1; i++) begin
      steer(0, 1);
      do_frame("to_rf");
    end
    chk("bounce_done", 32'(mdx), 32'd0);
    chk("bounce_score", 32'(score), 32'h0);
    probe("bounce_x", 608, my, 0);
    probe("bounce_left", 607, my, 0);

    for (int i = 0; i < 1000 && ms1 == 0 && ms2 == 0; i++) begin
      steer(2, 1);
      do_frame("to_left");
    end
    chk("miss_score", 32'(score), 32'h0001);
    chk("miss_state", 32'(state), 32'd1);
    probe("miss_ctr", 316, 236, 0);

    for (int i = 0; i < 6000 && mst != 4; i++) begin
      steer(1, 2);
      do_frame("to_win");
    end
    chk("win_state", 32'(state), 32'd4);
    chk("win_over", 32'(game_over), 32'd1);
    chk("win_score", 32'(score), 32'h0901);
    ctrl = 32'd3;
    do_frame("over_ctl");
    ctrl = 32'd1;
    do_frame("over_run");
    probe("over_bg", 100, 100, 0);

    @(negedge clk);
    vcount = 11'd100; ctrl = 32'd4;
    model_restart();
    sb_push("restart", 32'h0);
    @(negedge clk);
    ctrl = 32'd0;
    sb_pop({12'd0, game_over, state, score});
    chk("restart_state", 32'(state), 32'd0);

    y_pos_1 = 32'd1000;
    do_frame("latch");
    probe("clamp_top", 16, 416, 0);
    probe("clamp_above", 16, 415, 0);
    probe("clamp_bot", 16, 479, 0);
    probe("restart_ball", 316, 236, 0);
    probe("net_again", 319, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_engine.md
# pong_engine

Parametrised Pong game core: frame-rate ball/paddle physics, a serve/play/pause/game-over state machine, per-player score counting to a configurable win score, and registered pixel rendering. It sits between the MicroBlaze MCS GPIO outputs (paddle positions, control word), the VGA timing counters, and the seven-segment score display. Screen size, object geometry, speed, score width and colour depth are all parameters.

## Interface
- `H_RES`, 640, visible columns
- `V_RES`, 480, visible rows
- `PADDLE_H`, 64, paddle height in pixels
- `PADDLE_W`, 8, paddle width in pixels
- `PAD_MARGIN`, 16, gap between the screen edge and the paddle's outer edge
- `BALL_SIZE`, 8, square ball side in pixels
- `BALL_STEP`, 2, ball displacement per frame on each axis
- `SERVE_FRAMES`, 60, frames the ball waits in SERVE
- `WIN_SCORE`, 9, score that ends the game
- `SCORE_W`, 8, bits per player score
- `COLOR_W`, 4, bits per colour channel

Ports:
- `clk`  in  1  game clock; all logic runs on its rising edge
- `reset`  in  1  synchronous, active-high
- `hcount`, `vcount`  in  11  current pixel coordinates, synchronous to `clk`
- `blank`  in  1  high outside the visible area
- `y_pos_1`, `y_pos_2`  in  32  requested top row of left/right paddle, unsigned
- `ctrl`  in  32  bit0 run, bit1 pause, bit2 restart; other bits ignored
- `VGA_R`, `VGA_G`, `VGA_B`  out  COLOR_W  pixel colour
- `score`  out  2*SCORE_W  {p1, p2}, binary; p1 in the upper half
- `game_over`  out  1  high in state OVER
- `state`  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4

## Operation
- **Frame tick.** A one-cycle pulse on the first `clk` where `vcount == V_RES`, detected as the rising edge of a registered compare. All physics, paddle latching, and sampling of `ctrl` bit0/bit1 happen only on the tick.
- **Paddles.** On each tick, `p_y = min(y_pos, V_RES-PADDLE_H)`, using the full 32-bit compare before truncation.
- **Ball centre.** (CX, CY) = ((H_RES-BALL_SIZE)/2, (V_RES-BALL_SIZE)/2).
- **LF/RF.** LF = PAD_MARGIN+PADDLE_W. RF = H_RES-PAD_MARGIN-PADDLE_W-BALL_SIZE.

State machine:
- **IDLE.** Ball held at centre. On a tick with run=1, go to SERVE.
- **SERVE.** Ball held at centre. The frame counter counts SERVE_FRAMES ticks, then goes to PLAY.
- **PLAY.** On a tick with pause=1, go to PAUSE with no motion that frame. Otherwise, update the ball:
  - **Vertical.** y += ±BALL_STEP. If the result is ≤0, set y=0 and set dy=down. If it is ≥V_RES-BALL_SIZE, clamp and set dy=up.
  - **Left paddle.** When moving left and next x ≤ LF, the ball overlaps the left paddle if `y+BALL_SIZE > p1_y` and `y < p1_y+PADDLE_H`. On overlap, set x=LF and dx=right.
  - **Right paddle.** Symmetric, using RF and `p2_y`.
  - **Miss, left.** If the ball misses and next x ≤ 0, p2 gains a point.
  - **Miss, right.** If next x ≥ H_RES-BALL_SIZE, p1 gains a point.
  - **Both walls and paddle in one frame.** Axes are handled independently, so both reflections apply.
- **Point.** Increment the scorer's count. If the new value is WIN_SCORE, go to OVER. Otherwise go to SERVE with the ball at centre, dx toward the player who lost the point, and dy unchanged.
- **PAUSE.** Ball frozen. On a tick with pause=0, return to PLAY.
- **OVER.** Ball frozen; run and pause are ignored.
- **Restart.** restart=1 on any cycle, no tick needed, overrides everything next cycle: state IDLE, scores 0, ball at centre, dx right, dy down.
- **Scores.** A score never exceeds WIN_SCORE.

Rendering (priority high→low):
- `blank` → all channels 0.
- Ball square → all channels max.
- Left paddle → G max.
- Right paddle → B max.
- Net: columns H_RES/2-1 and H_RES/2 where vcount[3]=0 → all channels at half (MSB only).
- Background: in OVER, R at quarter (bit COLOR_W-2); otherwise 0.

## Timing
- Reset values:
  - `VGA_*` = 0, `score` = 0, `game_over` = 0, `state` = IDLE.
  - Ball at (CX, CY), dx right, dy down.
  - Paddles at (V_RES-PADDLE_H)/2.
  - Frame counter 0, tick register 0.
- **Colour latency.** Colours are registered: the output for the `hcount`/`vcount`/`blank` sampled at edge n appears after edge n. Latency is 1 clk.
- **Frame-tick latency.**
  - Tick asserts 2 clk after `vcount` first equals V_RES (compare register plus edge detect).
  - Physics results, `score`, and `state` update on the edge after the tick.
- **Restart.** Takes effect at the next edge. If restart and a point fall in the same cycle, restart wins.
- **Mid-frame reset.** Reset mid-frame clears the edge detector. No tick is generated until the next fresh `vcount == V_RES` crossing.

## Test plan
- **Reset.** Hold reset 3 clk → `VGA_*`=0, `score`=0, `state`=0, ball at (316,236), paddles at row 208.
- **Serve then play.** `ctrl`=1 → SERVE on the tick after run; PLAY after 60 further ticks. The ball then moves (+2,+2) per tick.
- **Paddle bounce.** Set `y_pos_2` to cover the ball's rows and let the ball reach RF=608 → x=608, dx left, `score` unchanged.
- **Miss.** Set `y_pos_1`=0 with the ball near row 400 and let it pass the left edge → `score`=0x0001, state SERVE, ball at centre, dx left.
- **Win and restart.** Drive p1 to 9 → `state`=4, `game_over`=1, and run has no effect. Pulse restart mid-frame → IDLE and `score`=0 on the next clk.
- **Render and clamp.**
  - Pixel inside the ball → 0xF on all channels one clk later.
  - `blank`=1 → 0.
  - `y_pos_1`=1000 → left paddle drawn on rows 416–479.
  - Net pixel at (319,0) → 0x8 on all channels.
